// File: rtl/ssd1306_frame_streamer.sv
// Streams one framebuffer to the SSD1306: an address-window command
// group followed by page-major pixel bytes, over the spi driver handshake.
module ssd1306_frame_streamer #(
  parameter int COLUMNS   = 128,
  parameter int PAGES     = 4,
  parameter int FB_ADDR_W = 9
) (
  input  logic                 clk_in,
  input  logic                 resetn_in,
  input  logic                 init_done,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  output logic [FB_ADDR_W-1:0] fb_addr,
  input  logic [7:0]           fb_data,
  output logic                 command_start,
  output logic [7:0]           command_out,
  output logic                 command_last_byte,
  input  logic                 command_ready,
  output logic                 oled_dc
);

  localparam int TOTAL = COLUMNS * PAGES;
  localparam int DW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [DW-1:0] LAST_IDX = DW'(TOTAL - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD_SEND,
    CMD_WAIT,
    FETCH,
    LOAD,
    DATA_SEND,
    DATA_WAIT,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   cs_q, cs_d;
  logic [7:0]             out_q, out_d;
  logic                   last_q, last_d;
  logic                   dc_q, dc_d;
  logic [FB_ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]             cmd_idx_q, cmd_idx_d;
  logic [DW-1:0]          data_idx_q, data_idx_d;
  logic [7:0]             pix_q, pix_d;
  logic                   guard_q, guard_d;
  logic [7:0]             cmd_byte;
  logic [DW-1:0]          data_idx_inc;

  assign busy              = busy_q;
  assign frame_done        = done_q;
  assign command_start     = cs_q;
  assign command_out       = out_q;
  assign command_last_byte = last_q;
  assign oled_dc           = dc_q;
  assign fb_addr           = addr_q;
  assign data_idx_inc      = data_idx_q + 1'b1;

  always_comb begin
    case (cmd_idx_q)
      3'd0:    cmd_byte = 8'h21;
      3'd1:    cmd_byte = 8'h00;
      3'd2:    cmd_byte = 8'(COLUMNS - 1);
      3'd3:    cmd_byte = 8'h22;
      3'd4:    cmd_byte = 8'h00;
      default: cmd_byte = 8'(PAGES - 1);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cs_d       = 1'b0;
    out_d      = out_q;
    last_d     = last_q;
    dc_d       = dc_q;
    addr_d     = addr_q;
    cmd_idx_d  = cmd_idx_q;
    data_idx_d = data_idx_q;
    pix_d      = pix_q;
    guard_d    = guard_q;
    // Losing init_done abandons the frame; byte outputs keep their value.
    if (state_q != IDLE && !init_done) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && init_done) begin
            state_d    = CMD_SEND;
            busy_d     = 1'b1;
            cmd_idx_d  = 3'd0;
            data_idx_d = '0;
          end
        end
        CMD_SEND: begin
          if (command_ready) begin
            cs_d    = 1'b1;
            out_d   = cmd_byte;
            last_d  = (cmd_idx_q == 3'd5);
            dc_d    = 1'b0;
            guard_d = 1'b1;
            state_d = CMD_WAIT;
          end
        end
        CMD_WAIT: begin
          if (guard_q) begin
            guard_d = 1'b0;
          end else if (command_ready) begin
            if (cmd_idx_q == 3'd5) begin
              state_d    = FETCH;
              data_idx_d = '0;
              addr_d     = '0;
            end else begin
              cmd_idx_d = cmd_idx_q + 3'd1;
              state_d   = CMD_SEND;
            end
          end
        end
        FETCH: state_d = LOAD;
        LOAD: begin
          pix_d   = fb_data;
          state_d = DATA_SEND;
        end
        DATA_SEND: begin
          if (command_ready) begin
            cs_d    = 1'b1;
            out_d   = pix_q;
            last_d  = (data_idx_q == LAST_IDX);
            dc_d    = 1'b1;
            guard_d = 1'b1;
            state_d = DATA_WAIT;
          end
        end
        DATA_WAIT: begin
          if (guard_q) begin
            guard_d = 1'b0;
          end else if (command_ready) begin
            if (data_idx_q == LAST_IDX) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              data_idx_d = data_idx_inc;
              addr_d     = FB_ADDR_W'(data_idx_inc);
              state_d    = FETCH;
            end
          end
        end
        DONE: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!resetn_in) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b0;
      out_q      <= 8'h00;
      last_q     <= 1'b0;
      dc_q       <= 1'b0;
      addr_q     <= '0;
      cmd_idx_q  <= 3'd0;
      data_idx_q <= '0;
      pix_q      <= 8'h00;
      guard_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      out_q      <= out_d;
      last_q     <= last_d;
      dc_q       <= dc_d;
      addr_q     <= addr_d;
      cmd_idx_q  <= cmd_idx_d;
      data_idx_q <= data_idx_d;
      pix_q      <= pix_d;
      guard_q    <= guard_d;
    end
  end

endmodule

// File: tb/tb_ssd1306_frame_streamer.sv
// Bench for ssd1306_frame_streamer: spi driver and framebuffer models,
// expected byte streams built from the frame format.
module tb_ssd1306_frame_streamer;

  localparam int C  = 4;
  localparam int P  = 2;
  localparam int AW = 9;
  localparam int N  = C * P;

  logic          clk = 1'b0;
  logic          resetn_in = 1'b0;
  logic          init_done = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          frame_done;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          command_start;
  logic [7:0]    command_out;
  logic          command_last_byte;
  logic          command_ready;
  logic          oled_dc;

  logic          spi_ready = 1'b1;
  logic          hold = 1'b0;
  int            spi_len = 10;
  int            spi_cnt = 0;
  logic [7:0]    fb [0:(1<<AW)-1];

  int            compared = 0;
  int            mismatched = 0;
  logic [9:0]    cap [$];
  logic [9:0]    exp_q [$];
  int            done_cnt = 0;

  logic          was_rst = 1'b1;
  logic          prev_cs = 1'b0;
  logic          prev_fd = 1'b0;
  logic [9:0]    held = '0;
  logic [AW-1:0] prev_addr = '0;

  ssd1306_frame_streamer #(
    .COLUMNS(C), .PAGES(P), .FB_ADDR_W(AW)
  ) dut (
    .clk_in(clk),
    .resetn_in(resetn_in),
    .init_done(init_done),
    .start(start),
    .busy(busy),
    .frame_done(frame_done),
    .fb_addr(fb_addr),
    .fb_data(fb_data),
    .command_start(command_start),
    .command_out(command_out),
    .command_last_byte(command_last_byte),
    .command_ready(command_ready),
    .oled_dc(oled_dc)
  );

  always #5 clk = ~clk;

  assign command_ready = spi_ready && !hold;

  always @(posedge clk) fb_data <= fb[fb_addr];

  // spi driver: ready drops the cycle after a start and stays low spi_len cycles
  always @(posedge clk) begin
    if (command_start) begin
      spi_ready <= 1'b0;
      spi_cnt   <= spi_len;
    end else if (!spi_ready) begin
      if (spi_cnt <= 1) spi_ready <= 1'b1;
      else spi_cnt <= spi_cnt - 1;
    end
  end

  always @(posedge clk) was_rst <= !resetn_in;

  always @(negedge clk) begin
    if (command_start) begin
      cap.push_back({oled_dc, command_last_byte, command_out});
      compared++;
      if (prev_cs) begin
        mismatched++;
        $display("FAIL cs_width: got 2+ cycles required 1");
      end
      compared++;
      if (command_ready !== 1'b1) begin
        mismatched++;
        $display("FAIL cs_ready: got ready=%b required 1", command_ready);
      end
    end else if (!was_rst) begin
      compared++;
      if ({oled_dc, command_last_byte, command_out} !== held) begin
        mismatched++;
        $display("FAIL out_hold: got %h required %h",
                 {oled_dc, command_last_byte, command_out}, held);
      end
    end
    if (command_start || was_rst)
      held = {oled_dc, command_last_byte, command_out};
    if (!was_rst && fb_addr !== prev_addr) begin
      compared++;
      if (!(fb_addr == prev_addr + 1'b1 || fb_addr == '0)) begin
        mismatched++;
        $display("FAIL fb_addr_seq: got %0d after %0d", fb_addr, prev_addr);
      end
    end
    prev_addr = fb_addr;
    if (frame_done) begin
      done_cnt++;
      compared++;
      if (prev_fd) begin
        mismatched++;
        $display("FAIL done_width: got 2+ cycles required 1");
      end
    end
    prev_cs = command_start;
    prev_fd = frame_done;
  end

  function automatic void build_exp();
    logic [7:0] cmds [6];
    cmds = '{8'h21, 8'h00, 8'(C - 1), 8'h22, 8'h00, 8'(P - 1)};
    exp_q.delete();
    for (int i = 0; i < 6; i++)
      exp_q.push_back({1'b0, (i == 5), cmds[i]});
    for (int i = 0; i < N; i++)
      exp_q.push_back({1'b1, (i == N - 1), fb[i]});
  endfunction

  task automatic fill_fb(input bit rnd);
    for (int i = 0; i < N; i++)
      fb[i] = rnd ? 8'($urandom) : 8'(8'hA0 + i);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frame(input int budget, input int d0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) ok = 1'b1;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL frame_timeout: got no frame_done required one");
    end
  endtask

  task automatic wait_cap(input int k, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (cap.size() >= k) ok = 1'b1;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL byte_timeout: got %0d bytes required %0d", cap.size(), k);
    end
  endtask

  task automatic wait_spi_idle();
    for (int i = 0; i < 200 && !spi_ready; i++) @(negedge clk);
  endtask

  task automatic check_stream(input string name);
    int n;
    build_exp();
    compared++;
    if (cap.size() != exp_q.size()) begin
      mismatched++;
      $display("FAIL %s_len: got %0d required %0d", name, cap.size(), exp_q.size());
    end
    n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      compared++;
      if (cap[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL %s[%0d]: got %h required %h", name, i, cap[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_reset_outs(input string name);
    logic [9:0]    outs;
    outs = {busy, frame_done, command_start, command_out[6:0]};
    compared++;
    if ({outs, command_out[7], command_last_byte, oled_dc} !== 13'h0) begin
      mismatched++;
      $display("FAIL %s_outs: got busy=%b fd=%b cs=%b out=%h last=%b dc=%b",
               name, busy, frame_done, command_start, command_out,
               command_last_byte, oled_dc);
    end
    compared++;
    if (fb_addr !== '0) begin
      mismatched++;
      $display("FAIL %s_addr: got %0d required 0", name, fb_addr);
    end
  endtask

  task automatic test_reset();
    resetn_in = 1'b0;
    init_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    resetn_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    int d0;
    fill_fb(1'b0);
    init_done = 1'b1;
    spi_len = 10;
    cap.delete();
    d0 = done_cnt;
    pulse_start();
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL frame_busy: got %b required 1", busy);
    end
    wait_frame(2000, d0);
    @(negedge clk);
    #1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL frame_idle: got busy=%b required 0", busy);
    end
    repeat (5) @(negedge clk);
    check_stream("frame");
    compared++;
    if (done_cnt - d0 != 1) begin
      mismatched++;
      $display("FAIL frame_done_cnt: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_ignored_start();
    int d0;
    init_done = 1'b0;
    cap.delete();
    pulse_start();
    repeat (20) @(negedge clk);
    compared++;
    if (cap.size() != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL no_init_start: got %0d bytes busy=%b required 0/0",
               cap.size(), busy);
    end
    init_done = 1'b1;
    fill_fb(1'b1);
    spi_len = $urandom_range(6, 12);
    d0 = done_cnt;
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_frame(2000, d0);
    repeat (60) @(negedge clk);
    check_stream("busy_start");
    compared++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_start_done: got %0d frames busy=%b required 1/0",
               done_cnt - d0, busy);
    end
  endtask

  task automatic test_ready_hold();
    int d0;
    bit bad;
    logic [9:0] snap;
    fill_fb(1'b1);
    spi_len = $urandom_range(4, 10);
    cap.delete();
    d0 = done_cnt;
    pulse_start();
    wait_cap(3, 500);
    @(posedge clk);
    #1;
    hold = 1'b1;
    @(negedge clk);
    snap = {oled_dc, command_last_byte, command_out};
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cap.size() != 3 || command_start ||
          {oled_dc, command_last_byte, command_out} !== snap)
        bad = 1'b1;
    end
    compared++;
    if (bad) begin
      mismatched++;
      $display("FAIL ready_hold: got activity/bytes=%0d required 3 stable",
               cap.size());
    end
    @(posedge clk);
    #1;
    hold = 1'b0;
    wait_frame(2000, d0);
    repeat (5) @(negedge clk);
    check_stream("hold");
  endtask

  task automatic test_reset_mid();
    int d0;
    fill_fb(1'b1);
    spi_len = 10;
    cap.delete();
    pulse_start();
    wait_cap(10, 1000);
    resetn_in = 1'b0;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    check_reset_outs("mid_reset");
    @(negedge clk);
    resetn_in = 1'b1;
    repeat (30) @(negedge clk);
    compared++;
    if (done_cnt != d0 || cap.size() != 10) begin
      mismatched++;
      $display("FAIL mid_reset_quiet: got %0d frames %0d bytes required 0/10",
               done_cnt - d0, cap.size());
    end
    wait_spi_idle();
    fill_fb(1'b1);
    cap.delete();
    d0 = done_cnt;
    pulse_start();
    wait_frame(2000, d0);
    repeat (5) @(negedge clk);
    check_stream("after_reset");
  endtask

  task automatic test_init_drop();
    int d0;
    fill_fb(1'b1);
    spi_len = 8;
    cap.delete();
    d0 = done_cnt;
    pulse_start();
    wait_cap(2, 500);
    repeat (2) @(negedge clk);
    init_done = 1'b0;
    @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL init_drop_busy: got %b required 0", busy);
    end
    repeat (40) @(negedge clk);
    compared++;
    if (cap.size() != 2 || done_cnt != d0) begin
      mismatched++;
      $display("FAIL init_drop_quiet: got %0d bytes %0d frames required 2/0",
               cap.size(), done_cnt - d0);
    end
    init_done = 1'b1;
    wait_spi_idle();
  endtask

  task automatic test_back_to_back();
    int d0;
    for (int f = 0; f < 3; f++) begin
      fill_fb(1'b1);
      spi_len = $urandom_range(2, 9);
      cap.delete();
      d0 = done_cnt;
      pulse_start();
      wait_frame(2000, d0);
      check_stream("b2b");
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_ignored_start();
    test_ready_hold();
    test_reset_mid();
    test_init_drop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
